// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: owns the RTC multiplexed address/data bus.
// Periodic read bursts refresh a nine-byte shadow bank, and commit-driven
// write bursts push the enabled bytes back to the RTC. Each register access
// is ADDR -> GAP1 -> DATA -> GAP2, and each phase lasts T_PHASE clocks.
module rtc_bus_scheduler #(
  parameter int T_PHASE     = 4,
  parameter int SCAN_PERIOD = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_req,
  input  logic [71:0] wr_data,
  input  logic [8:0]  wr_mask,
  input  logic [7:0]  ad_in,
  output logic [71:0] rd_data,
  output logic        rd_valid,
  output logic        wr_done,
  output logic        busy,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        a_d,
  output logic [7:0]  ad_out,
  output logic        ad_oe
);

  localparam int PH_W = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam int SC_W = $clog2(SCAN_PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(T_PHASE - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2} state_e;

  // RTC address of each shadow-bank index.
  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h41;
      4'd7:    a = 8'h42;
      4'd8:    a = 8'h43;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // Lowest set mask bit at or above start; bit 4 of the result flags "found".
  function automatic logic [4:0] next_set(input logic [8:0] mask, input logic [3:0] start);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 8; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [3:0]        idx_q, idx_d;
  logic              is_wr_q, is_wr_d;
  logic              wr_pend_q, wr_pend_d;
  logic              scan_pend_q, scan_pend_d;
  logic              rearm_q, rearm_d;
  logic [SC_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [71:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_done_q, wr_done_d;
  logic [71:0]       staging_q, staging_d;
  logic [71:0]       wdata_q, wdata_d;
  logic [8:0]        mask_q, mask_d;

  logic              scan_wrap, phase_last, wr_active, rd_active;
  logic              launch, launch_wr, launch_rd, read_exit;
  logic [4:0]        nxt;

  // Next-state logic: phase sequencing, burst stepping, request flags, arbitration.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    is_wr_d     = is_wr_q;
    wr_pend_d   = wr_pend_q;
    scan_pend_d = scan_pend_q;
    rearm_d     = rearm_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    wr_done_d   = 1'b0;
    staging_d   = staging_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    launch      = 1'b0;
    launch_wr   = 1'b0;
    launch_rd   = 1'b0;
    read_exit   = 1'b0;
    nxt         = 5'd0;

    scan_wrap  = (scan_cnt_q == SC_LAST);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    phase_last = (phase_q == PH_LAST);
    wr_active  = (state_q != IDLE) && is_wr_q;
    rd_active  = (state_q != IDLE) && !is_wr_q;

    // A commit is accepted only once; repeats are dropped until its burst ends.
    if (write_req && !wr_pend_q && !wr_active) wr_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        launch    = 1'b1;
        launch_wr = wr_pend_q;
        launch_rd = scan_pend_q;
      end
      ADDR, GAP1, DATA: begin
        if ((state_q == DATA) && !is_wr_q && phase_last) staging_d[{idx_q, 3'b000} +: 8] = ad_in;
        if (phase_last) begin
          phase_d = '0;
          state_d = (state_q == ADDR) ? GAP1 : (state_q == GAP1) ? DATA : GAP2;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      GAP2: begin
        if (!phase_last) begin
          phase_d = phase_q + 1'b1;
        end else begin
          phase_d = '0;
          if (is_wr_q) begin
            nxt = next_set(mask_q, idx_q + 4'd1);
            if (nxt[4]) begin
              idx_d   = nxt[3:0];
              state_d = ADDR;
            end else begin
              state_d   = IDLE;
              wr_done_d = 1'b1;
              wr_pend_d = 1'b0;
              launch    = 1'b1;
              launch_rd = scan_pend_q;
            end
          end else if (idx_q == 4'd8) begin
            // Atomic shadow update: all nine bytes change on the same edge.
            state_d     = IDLE;
            read_exit   = 1'b1;
            rd_data_d   = staging_q;
            rd_valid_d  = 1'b1;
            scan_pend_d = rearm_q;
            rearm_d     = 1'b0;
            launch      = 1'b1;
            launch_wr   = wr_pend_q;
            launch_rd   = rearm_q;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Arbitration: writes beat scans; at a burst end the next burst starts without an idle cycle.
    if (launch) begin
      if (launch_wr) begin
        if (wr_mask == 9'd0) begin
          wr_done_d = 1'b1;
          wr_pend_d = 1'b0;
        end else begin
          nxt     = next_set(wr_mask, 4'd0);
          is_wr_d = 1'b1;
          mask_d  = wr_mask;
          wdata_d = wr_data;
          idx_d   = nxt[3:0];
          state_d = ADDR;
        end
      end else if (launch_rd) begin
        is_wr_d = 1'b0;
        idx_d   = 4'd0;
        state_d = ADDR;
      end
    end

    // A wrap while a read burst is in flight must trigger another read afterwards.
    if (scan_wrap) begin
      scan_pend_d = 1'b1;
      if (rd_active && !read_exit) rearm_d = 1'b1;
    end
  end

  // Control state with synchronous reset; a reset aborts any burst immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      idx_q       <= 4'd0;
      is_wr_q     <= 1'b0;
      wr_pend_q   <= 1'b0;
      scan_pend_q <= 1'b0;
      rearm_q     <= 1'b0;
      scan_cnt_q  <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      is_wr_q     <= is_wr_d;
      wr_pend_q   <= wr_pend_d;
      scan_pend_q <= scan_pend_d;
      rearm_q     <= rearm_d;
      scan_cnt_q  <= scan_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_done_q   <= wr_done_d;
    end
  end

  // Datapath registers: staging and latched write data.
  // NOTE: these are left out of reset because every byte is rewritten before it is ever used.
  always_ff @(posedge clk) begin
    staging_q <= staging_d;
    wdata_q   <= wdata_d;
    mask_q    <= mask_d;
  end

  // Bus strobes and drive value decoded from the current phase.
  always_comb begin
    cs_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    a_d    = 1'b0;
    ad_out = 8'h00;
    ad_oe  = 1'b0;
    case (state_q)
      ADDR: begin
        cs_n   = 1'b0;
        wr_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = reg_addr(idx_q);
      end
      DATA: begin
        cs_n = 1'b0;
        a_d  = 1'b1;
        if (is_wr_q) begin
          wr_n   = 1'b0;
          ad_oe  = 1'b1;
          ad_out = wdata_q[{idx_q, 3'b000} +: 8];
        end else begin
          rd_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_done  = wr_done_q;
  assign busy     = wr_pend_q | scan_pend_q | (state_q != IDLE);

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Testbench for rtc_bus_scheduler with T_PHASE=2 and SCAN_PERIOD=200.
// The stimulus pushes expected bus accesses and pulses into a queue, and a
// negedge monitor pops and compares each one as the DUT produces it.
module tb_rtc_bus_scheduler;

  localparam int T_PHASE     = 2;
  localparam int SCAN_PERIOD = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_req = 1'b0;
  logic [71:0] wr_data = '0;
  logic [8:0]  wr_mask = '0;
  logic [7:0]  ad_in = '0;
  logic [71:0] rd_data;
  logic        rd_valid, wr_done, busy, cs_n, rd_n, wr_n, a_d, ad_oe;
  logic [7:0]  ad_out;

  rtc_bus_scheduler #(.T_PHASE(T_PHASE), .SCAN_PERIOD(SCAN_PERIOD)) dut (
    .clk(clk), .reset(reset), .write_req(write_req), .wr_data(wr_data),
    .wr_mask(wr_mask), .ad_in(ad_in), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_done(wr_done), .busy(busy), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .a_d(a_d), .ad_out(ad_out), .ad_oe(ad_oe)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_RD, EV_WR, EV_RDV, EV_DONE} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [7:0]  addr;
    logic [71:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         e_cyc, bl, cl, rl;
  logic [7:0] rd_offset = 8'h10;
  logic [7:0] addr_tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  // Clock edges since reset release: after edge n, cyc == n.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- expectation helpers ----------------
  function automatic logic [71:0] exp_rd(input logic [7:0] off);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = addr_tbl[i] + off;
    return v;
  endfunction

  task automatic push_ev(input ev_kind_e k, input logic [7:0] a, input logic [71:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_read_burst(input logic [7:0] off);
    for (int i = 0; i < 9; i++) push_ev(EV_RD, addr_tbl[i], 72'd0);
    push_ev(EV_RDV, 8'h00, exp_rd(off));
  endtask

  // A write access shows ad_oe=1 together with the data byte.
  task automatic push_write(input logic [7:0] a, input logic [7:0] b);
    push_ev(EV_WR, a, {63'd0, 1'b1, b});
  endtask

  // ---------------- RTC bus model ----------------
  always @(negedge clk) begin
    if (!reset && !cs_n && !a_d) ad_in = ad_out + rd_offset;
  end

  // ---------------- monitor / scoreboard ----------------
  logic       prev_data = 1'b0;
  logic [7:0] last_addr = 8'h00;
  ev_t        mon_act;

  task automatic sb_compare(input ev_t act);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: got event 0x%0h with nothing expected", act);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("sb_%s", act.kind.name()), act, e);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_data = 1'b0;
    end else begin
      if (!cs_n && !a_d) last_addr = ad_out;
      if (!cs_n && a_d && !prev_data) begin
        mon_act      = '0;
        mon_act.addr = last_addr;
        if (!wr_n) begin
          mon_act.kind = EV_WR;
          mon_act.data = {63'd0, ad_oe, ad_out};
        end else begin
          mon_act.kind = EV_RD;
          mon_act.data = {70'd0, ad_oe, rd_n};
        end
        sb_compare(mon_act);
      end
      prev_data = !cs_n && a_d;
      if (rd_valid) begin
        mon_act      = '0;
        mon_act.kind = EV_RDV;
        mon_act.data = rd_data;
        sb_compare(mon_act);
      end
      if (wr_done) begin
        mon_act      = '0;
        mon_act.kind = EV_DONE;
        sb_compare(mon_act);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Waits for sel (0: cs_n low, 1: rd_valid, 2: wr_done), tallying busy-low,
  // cs_n-low and rd_n-low samples seen before the event.
  task automatic wait_ev(input int sel, input string name, input int limit,
                         output int busy_lows, output int cs_lows, output int rd_lows);
    bit hit;
    hit = 1'b0;
    busy_lows = 0;
    cs_lows = 0;
    rd_lows = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if ((sel == 0 && !cs_n) || (sel == 1 && rd_valid) || (sel == 2 && wr_done)) begin
        hit = 1'b1;
        break;
      end
      if (!busy) busy_lows++;
      if (!cs_n) cs_lows++;
      if (!rd_n) rd_lows++;
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: event not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called at a negedge; write_req is sampled at the next edge, returned as e.
  task automatic pulse_write(output int e);
    write_req = 1'b1;
    @(negedge clk);
    e = cyc;
    write_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset_outputs", {cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, busy, rd_valid, wr_done},
          {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    check("reset_rd_data", rd_data, 72'd0);
    reset = 1'b0;

    // ---- first scan read burst ----
    push_read_burst(8'h10);
    wait_ev(0, "first_cs", 400, bl, cl, rl);
    check("first_cs_cycle", cyc, 202 - 1);
    wait_ev(1, "rd_valid1", 200, bl, cl, rl);
    check("rd_valid1_cycle", cyc, 201 + 72);
    check("busy_falls_with_rdv1", busy, 1'b0);

    // ---- write, mask 0x005 ----
    wait_until(279);
    wr_mask = 9'h005;
    wr_data = {8'hA8, 8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'h23, 8'hA1, 8'h59};
    push_write(8'h21, 8'h59);
    push_write(8'h23, 8'h23);
    push_ev(EV_DONE, 8'h00, 72'd0);
    pulse_write(e_cyc);
    check("wr1_busy_after_req", busy, 1'b1);
    wait_ev(0, "wr1_cs", 20, bl, cl, rl);
    check("wr1_cs_cycle", cyc, e_cyc + 1);
    wait_ev(2, "wr1_done", 40, bl, cl, rl);
    check("wr1_done_cycle", cyc, e_cyc + 17);
    check("wr1_no_rd_strobe", rl, 0);
    check("wr1_busy_falls", busy, 1'b0);

    // ---- write request during a read burst, then an ignored repeat ----
    rd_offset = 8'h20;
    push_read_burst(8'h20);
    wait_until(419);
    wr_mask = 9'h1FF;
    wr_data = {8'h89, 8'h88, 8'h87, 8'h86, 8'h85, 8'h84, 8'h83, 8'h82, 8'h81};
    for (int i = 0; i < 9; i++) push_write(addr_tbl[i], 8'h81 + 8'(i));
    push_ev(EV_DONE, 8'h00, 72'd0);
    pulse_write(e_cyc);
    wait_ev(1, "rd_valid2", 100, bl, cl, rl);
    check("rd_valid2_cycle", cyc, 401 + 72);
    check("rd_to_wr_no_idle", cs_n, 1'b0);
    check("busy_high_during_read2", bl, 0);
    wait_until(499);
    pulse_write(e_cyc);
    wait_ev(2, "wr2_done", 100, bl, cl, rl);
    check("wr2_done_cycle", cyc, 473 + 72);
    check("busy_high_during_wr2", bl, 0);
    check("wr2_busy_falls", busy, 1'b0);

    // ---- scan wrap and write_req on the same edge ----
    rd_offset = 8'h30;
    push_write(8'h22, 8'hC1);
    push_write(8'h43, 8'hC8);
    push_ev(EV_DONE, 8'h00, 72'd0);
    push_read_burst(8'h30);
    wait_until(599);
    wr_mask = 9'h102;
    wr_data = {8'hC8, 8'hC7, 8'hC6, 8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0};
    pulse_write(e_cyc);
    check("wrap_edge_is_600", e_cyc, 600);
    wait_ev(2, "wr3_done", 40, bl, cl, rl);
    check("wr3_done_cycle", cyc, 600 + 17);
    check("wr_to_rd_no_idle", cs_n, 1'b0);
    wait_ev(1, "rd_valid3", 100, bl, cl, rl);
    check("rd_valid3_cycle", cyc, 617 + 72);

    // ---- write with empty mask ----
    wait_until(699);
    wr_mask = 9'h000;
    push_ev(EV_DONE, 8'h00, 72'd0);
    pulse_write(e_cyc);
    check("wr0_busy_after_req", busy, 1'b1);
    wait_ev(2, "wr0_done", 10, bl, cl, rl);
    check("wr0_done_cycle", cyc, e_cyc + 1);
    check("wr0_no_strobes", cl, 0);
    check("wr0_busy_falls", busy, 1'b0);

    // ---- reset in the middle of a read burst ----
    push_ev(EV_RD, 8'h21, 72'd0);
    wait_until(810);
    reset = 1'b1;
    @(negedge clk);
    check("abort_strobes", {cs_n, rd_n, wr_n, ad_oe, busy}, 5'b11100);
    check("abort_rd_data", rd_data, 72'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_offset = 8'h40;
    push_read_burst(8'h40);
    wait_ev(0, "post_reset_cs", 400, bl, cl, rl);
    check("post_reset_cs_cycle", cyc, 202 - 1);
    check("post_reset_rd_data_zero", rd_data, 72'd0);
    wait_ev(1, "rd_valid4", 200, bl, cl, rl);
    check("rd_valid4_cycle", cyc, 201 + 72);

    repeat (3) @(negedge clk);
    check("sb_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
